bob_rd_sched: RTL and testbench
===============================

Name: bob_rd_sched

Overview:
- Read-port scheduler for the 48-entry branch-order buffer RAM (single registered-address read port, 1-cycle read latency).
- Shares the read port between three requesters:
  - the in-order retire stream;
  - random-access lookups from branch execution;
  - an exception-recovery walk FSM, which reads the live entries between two pointers.
- Drives the RAM read_clkEn/read_addr and tags each returning data beat with its source.

Parameters:
- ADDR_WIDTH, 6, buffer index width.
- ADDR_COUNT, 48, number of valid entries; indices wrap ADDR_COUNT-1 -> 0.
- STARVE_LIM, 3, consecutive lookup denials after which lookup beats retire for one grant.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ret_req  in  1  retire read request
- ret_addr  in  6  retire entry index
- ret_gnt  out  1  retire granted this cycle (combinational)
- lookup_req  in  1  lookup read request
- lookup_addr  in  6  lookup entry index
- lookup_gnt  out  1  lookup granted this cycle (combinational)
- walk_start  in  1  start recovery walk (1-cycle pulse)
- walk_from  in  6  first index to read (inclusive)
- walk_to  in  6  end index (exclusive)
- walk_busy  out  1  walk FSM not idle
- walk_done  out  1  1-cycle pulse when walk completes
- addr_err  out  1  1-cycle pulse: a requester presented an index >= ADDR_COUNT
- ram_read_clkEn  out  1  to RAM read_clkEn
- ram_read_addr  out  6  to RAM read_addr
- rsp_vld  out  1  RAM read_data valid this cycle
- rsp_src  out  2  source of rsp: 0 retire, 1 lookup, 2 walk
- rsp_addr  out  6  index of the entry on read_data

Behaviour:
- Reset values: all gnt outputs, walk_busy, walk_done, addr_err, rsp_vld, ram_read_clkEn = 0; rsp_src = 0, rsp_addr = 0; FSM = IDLE; walk pointer = 0; starve counter = 0.
- Grant is combinational in cycle T. ram_read_clkEn = 1 and ram_read_addr = granted index in T. In T+1: rsp_vld = 1, with rsp_src/rsp_addr registered from T. When no grant: ram_read_clkEn = 0, and rsp_vld = 0 next cycle.
- At most one grant per cycle. Priority:
  1. walk (state WALK);
  2. lookup, if starve counter == STARVE_LIM;
  3. retire;
  4. lookup.
- Starve counter:
  - +1 (saturating at STARVE_LIM) on a cycle where lookup_req is valid but not granted;
  - cleared on lookup grant or when lookup_req = 0;
  - does not increment during WALK.
- Index check: a request with index >= ADDR_COUNT is never granted. addr_err pulses the same cycle, and the request does not count as a denial. Other valid requesters arbitrate normally.
- FSM states IDLE, WALK, DONE:
  - IDLE: on walk_start, load ptr = walk_from and latch walk_to. If walk_from == walk_to, go to DONE; else go to WALK. walk_from or walk_to >= ADDR_COUNT: addr_err pulses and the FSM stays in IDLE.
  - WALK: grant walk with index = ptr every cycle. Advance ptr = (ptr == ADDR_COUNT-1) ? 0 : ptr+1. When the advanced ptr == walk_to, go to DONE. Walk length = (walk_to - walk_from) mod 48, range 1..47.
  - DONE: walk_done = 1 for one cycle, then IDLE. walk_done coincides with rsp_vld of the last walk beat.
- walk_busy = 1 in WALK and DONE. walk_start while busy is ignored.
- Retire and lookup requests are blocked (gnt = 0) during WALK. Retire and lookup may be granted in the IDLE cycle that accepts walk_start and in the DONE cycle.
- Wrap-around: walk_from = 46, walk_to = 2 reads 46, 47, 0, 1.
- rst mid-walk: FSM returns to IDLE next cycle, and the in-flight beat is dropped (rsp_vld = 0 after reset).

Test Plan:
- ret_req = 1 with ret_addr = 5 and lookup_req = 1 with lookup_addr = 9, held for 5 cycles:
  - cycles 0-2: ret_gnt;
  - cycle 3: lookup_gnt (starve = 3);
  - next cycle: rsp_src = 1, rsp_addr = 9;
  - cycle 4: ret_gnt again.
- walk_start with from = 10, to = 13:
  - walk_busy high for 4 cycles;
  - rsp_src = 2 with rsp_addr = 10, 11, 12 on consecutive cycles;
  - walk_done aligned with rsp_addr = 12;
  - ret_req during WALK gets no gnt.
- walk_start with from = 46, to = 2 -> rsp_addr sequence 46, 47, 0, 1, then walk_done.
- walk_start with from = to = 20 -> no RAM reads, walk_done one cycle after start.
- lookup_addr = 50 with ret_req = 0 -> no grant, addr_err pulse, ram_read_clkEn = 0.
- rst asserted on the 2nd cycle of a walk (from = 0, to = 8) -> next cycle: walk_busy = 0 and rsp_vld = 0; a new walk_start is accepted normally.

Source files
------------

// File: rtl/bob_rd_sched.sv
// Read-port scheduler for the branch-order buffer RAM: arbitrates retire, lookup
// and the exception-recovery walk onto one registered-address read port.
module bob_rd_sched #(
    parameter int ADDR_WIDTH = 6,
    parameter int ADDR_COUNT = 48,
    parameter int STARVE_LIM = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ret_req,
    input  logic [ADDR_WIDTH-1:0] ret_addr,
    output logic                  ret_gnt,
    input  logic                  lookup_req,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_gnt,
    input  logic                  walk_start,
    input  logic [ADDR_WIDTH-1:0] walk_from,
    input  logic [ADDR_WIDTH-1:0] walk_to,
    output logic                  walk_busy,
    output logic                  walk_done,
    output logic                  addr_err,
    output logic                  ram_read_clkEn,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  rsp_vld,
    output logic [1:0]            rsp_src,
    output logic [ADDR_WIDTH-1:0] rsp_addr
);
    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
    localparam logic [1:0] SRC_RET = 2'd0, SRC_LKP = 2'd1, SRC_WALK = 2'd2;
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [ADDR_WIDTH:0]   CNT  = (ADDR_WIDTH+1)'(ADDR_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ADDR_COUNT - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] ptr, ptr_nxt, to_q;
    logic [SW-1:0]         starve;
    logic [1:0]            gnt_src;
    logic                  walk_gnt;

    // Zero-extend before comparing so ADDR_COUNT == 2**ADDR_WIDTH still works.
    wire ret_in   = {1'b0, ret_addr}    < CNT;
    wire lk_in    = {1'b0, lookup_addr} < CNT;
    wire range_in = ({1'b0, walk_from} < CNT) && ({1'b0, walk_to} < CNT);
    wire ret_ok   = ret_req && ret_in;
    wire lk_ok    = lookup_req && lk_in;
    wire walk_ok  = (state == IDLE) && walk_start && range_in;
    wire starved  = (starve == SW'(STARVE_LIM));

    assign ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (walk_ok) state_nxt = (walk_from == walk_to) ? DONE : WALK;
            WALK:    if (ptr_nxt == to_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ret_gnt        = 1'b0;
        lookup_gnt     = 1'b0;
        walk_gnt       = 1'b0;
        ram_read_addr  = '0;
        gnt_src        = SRC_RET;
        walk_busy      = (state != IDLE);
        walk_done      = (state == DONE);
        addr_err       = !rst && ((ret_req && !ret_in) || (lookup_req && !lk_in) ||
                                  ((state == IDLE) && walk_start && !range_in));
        if (!rst) begin
            if (state == WALK) begin
                walk_gnt = 1'b1; ram_read_addr = ptr; gnt_src = SRC_WALK;
            end else if (lk_ok && starved) begin
                lookup_gnt = 1'b1; ram_read_addr = lookup_addr; gnt_src = SRC_LKP;
            end else if (ret_ok) begin
                ret_gnt = 1'b1; ram_read_addr = ret_addr; gnt_src = SRC_RET;
            end else if (lk_ok) begin
                lookup_gnt = 1'b1; ram_read_addr = lookup_addr; gnt_src = SRC_LKP;
            end
        end
        ram_read_clkEn = ret_gnt | lookup_gnt | walk_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= '0;
            to_q <= '0;
        end else if (walk_ok) begin
            ptr  <= walk_from;
            to_q <= walk_to;
        end else if (state == WALK) begin
            ptr  <= ptr_nxt;
        end
    end

    // Out-of-range lookups neither count as denials nor reset the count.
    always_ff @(posedge clk) begin
        if (rst)                            starve <= '0;
        else if (lookup_gnt || !lookup_req) starve <= '0;
        else if (lk_ok && state != WALK && !starved) starve <= starve + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld  <= 1'b0;
            rsp_src  <= SRC_RET;
            rsp_addr <= '0;
        end else begin
            rsp_vld  <= ram_read_clkEn;
            rsp_src  <= gnt_src;
            rsp_addr <= ram_read_addr;
        end
    end
endmodule

// File: tb/tb_bob_rd_sched.sv
// Directed bench for bob_rd_sched: arbitration, starvation, recovery walks,
// index errors and mid-walk reset, with hand-computed expectations.
module tb_bob_rd_sched;
    logic       clk = 1'b0, rst = 1'b1;
    logic       ret_req = 0, lookup_req = 0, walk_start = 0;
    logic [5:0] ret_addr = 0, lookup_addr = 0, walk_from = 0, walk_to = 0;
    logic       ret_gnt, lookup_gnt, walk_busy, walk_done, addr_err;
    logic       ram_read_clkEn, rsp_vld;
    logic [5:0] ram_read_addr, rsp_addr;
    logic [1:0] rsp_src;
    int         nvec = 0, nerr = 0;

    bob_rd_sched dut (
        .clk(clk), .rst(rst),
        .ret_req(ret_req), .ret_addr(ret_addr), .ret_gnt(ret_gnt),
        .lookup_req(lookup_req), .lookup_addr(lookup_addr), .lookup_gnt(lookup_gnt),
        .walk_start(walk_start), .walk_from(walk_from), .walk_to(walk_to),
        .walk_busy(walk_busy), .walk_done(walk_done), .addr_err(addr_err),
        .ram_read_clkEn(ram_read_clkEn), .ram_read_addr(ram_read_addr),
        .rsp_vld(rsp_vld), .rsp_src(rsp_src), .rsp_addr(rsp_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 unit after the edge; outputs are sampled 3 units after it.
    task automatic next();
        @(posedge clk); #1;
    endtask
    task automatic settle();
        #2;
    endtask

    // One recovery walk; expected read order is from, from+1, ... mod 48.
    task automatic walk_run(input logic [5:0] from, input logic [5:0] to, input bit ret_on);
        int   n;
        bit   pv;
        logic [1:0] ps;
        logic [5:0] pa, ea;
        n = (int'(to) - int'(from) + 48) % 48;
        next();
        walk_start = 1; walk_from = from; walk_to = to;
        ret_req = ret_on; ret_addr = 6'd3; lookup_req = 0;
        settle();
        chk("start_busy", walk_busy, 0);
        chk("start_ret_gnt", ret_gnt, ret_on);
        chk("start_err", addr_err, 0);
        pv = ret_on; ps = 2'd0; pa = 6'd3;
        for (int k = 0; k < n; k++) begin
            next();
            walk_start = 0;
            settle();
            ea = 6'((int'(from) + k) % 48);
            chk("walk_busy", walk_busy, 1);
            chk("walk_done_early", walk_done, 0);
            chk("walk_ret_blocked", ret_gnt, 0);
            chk("walk_clkEn", ram_read_clkEn, 1);
            chk("walk_ram_addr", ram_read_addr, ea);
            chk("walk_rsp_vld", rsp_vld, pv);
            if (pv) begin
                chk("walk_rsp_src", rsp_src, ps);
                chk("walk_rsp_addr", rsp_addr, pa);
            end
            pv = 1; ps = 2'd2; pa = ea;
        end
        next();
        walk_start = 0;
        settle();
        chk("done_busy", walk_busy, 1);
        chk("done_pulse", walk_done, 1);
        chk("done_rsp_vld", rsp_vld, pv);
        if (pv) begin
            chk("done_rsp_src", rsp_src, ps);
            chk("done_rsp_addr", rsp_addr, pa);
        end
        chk("done_ret_gnt", ret_gnt, ret_on);
        chk("done_clkEn", ram_read_clkEn, ret_on);
        next();
        ret_req = 0;
        settle();
        chk("idle_busy", walk_busy, 0);
        chk("idle_done", walk_done, 0);
        chk("idle_rsp_vld", rsp_vld, ret_on);
        if (ret_on) chk("idle_rsp_src", rsp_src, 0);
    endtask

    initial begin
        bit   eg_ret [5] = '{1, 1, 1, 0, 1};
        logic [5:0] eaddr [5] = '{5, 5, 5, 9, 5};
        logic [1:0] esrc  [5] = '{0, 0, 0, 1, 0};

        // Reset state
        repeat (3) next();
        settle();
        chk("rst_ret_gnt", ret_gnt, 0);
        chk("rst_clkEn", ram_read_clkEn, 0);
        chk("rst_busy", walk_busy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_src", rsp_src, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        next();
        rst = 0;

        // Retire vs lookup with starvation override on the 4th cycle
        for (int i = 0; i < 5; i++) begin
            next();
            ret_req = 1; ret_addr = 6'd5; lookup_req = 1; lookup_addr = 6'd9;
            settle();
            chk("arb_ret_gnt", ret_gnt, eg_ret[i]);
            chk("arb_lkp_gnt", lookup_gnt, !eg_ret[i]);
            chk("arb_ram_addr", ram_read_addr, eaddr[i]);
            if (i > 0) begin
                chk("arb_rsp_vld", rsp_vld, 1);
                chk("arb_rsp_src", rsp_src, esrc[i-1]);
                chk("arb_rsp_addr", rsp_addr, eaddr[i-1]);
            end
        end
        next();
        ret_req = 0; lookup_req = 0;
        settle();
        chk("arb_last_rsp", rsp_addr, 5);
        chk("arb_idle_clkEn", ram_read_clkEn, 0);

        walk_run(6'd10, 6'd13, 1);
        walk_run(6'd46, 6'd2, 0);
        walk_run(6'd20, 6'd20, 0);

        // Out-of-range lookup: no grant, error pulse
        next();
        lookup_req = 1; lookup_addr = 6'd50;
        settle();
        chk("oor_lkp_gnt", lookup_gnt, 0);
        chk("oor_err", addr_err, 1);
        chk("oor_clkEn", ram_read_clkEn, 0);
        // Bad retire index while a good lookup still gets through
        next();
        ret_req = 1; ret_addr = 6'd48; lookup_addr = 6'd9;
        settle();
        chk("oor_rsp_vld", rsp_vld, 0);
        chk("oor_ret_gnt", ret_gnt, 0);
        chk("oor_lkp_ok", lookup_gnt, 1);
        chk("oor_err2", addr_err, 1);
        next();
        ret_req = 0; lookup_req = 0;
        settle();
        chk("oor_err_clear", addr_err, 0);
        // Walk with bad range is refused
        next();
        walk_start = 1; walk_from = 6'd48; walk_to = 6'd3;
        settle();
        chk("oor_walk_err", addr_err, 1);
        next();
        walk_start = 0;
        settle();
        chk("oor_walk_idle", walk_busy, 0);

        // Reset on the second walk cycle
        next();
        walk_start = 1; walk_from = 6'd0; walk_to = 6'd8;
        next();
        walk_start = 0;
        settle();
        chk("rw_first_addr", ram_read_addr, 0);
        next();
        rst = 1;
        next();
        rst = 0;
        settle();
        chk("rw_busy", walk_busy, 0);
        chk("rw_rsp_vld", rsp_vld, 0);
        walk_run(6'd5, 6'd7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
